// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : shared operation, mode and sequencer-state encodings for the ALU
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  typedef enum logic [2:0] {
    TRANSFER = 3'd0,
    INC      = 3'd1,
    ADD      = 3'd2,
    ADC      = 3'd3,
    SUB      = 3'd4,
    SBB      = 3'd5,
    DEC      = 3'd6,
    NEG      = 3'd7
  } opsel_e;

  typedef enum logic {
    ARITH = 1'b0,
    LOGIC = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/carry_init.sv
// ---------------------------------------------------------------------------
// carry_init : initial carry-in (c0) from operation, mode and carry flag
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module carry_init
  import alu_pkg::*;
(
  input  opsel_e opsel,
  input  mode_e  mode,
  input  logic   carry_flag,
  output logic   c0
);

  always_comb begin
    c0 = 1'b0;
    if (mode == ARITH) begin
      case (opsel)
        INC, SUB, NEG: c0 = 1'b1;
        ADC, SBB:      c0 = carry_flag;
        default:       c0 = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_carry_seq.sv
// ---------------------------------------------------------------------------
// alu_carry_seq : runs one wide operation as LS-first slice beats, chaining carry
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_carry_seq
  import alu_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int SLICE_W = 32,
  localparam int NUM_SLICES = DATA_W / SLICE_W,
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Opsel,
  input  logic             Mode,
  output logic             SliceValid,
  input  logic             SliceReady,
  output logic [IDX_W-1:0] SliceIdx,
  output logic             SliceCarryIn,
  input  logic             SliceCarryOut,
  output logic             Busy,
  output logic             Done,
  output logic             CarryFlag
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  if ((DATA_W % SLICE_W) != 0 || NUM_SLICES < 1) begin : g_bad_geometry
    $error("alu_carry_seq: DATA_W must be a non-zero multiple of SLICE_W");
  end

  seq_state_e       state;
  seq_state_e       state_next;
  mode_e            mode_q;
  logic [IDX_W-1:0] idx_q;
  logic             cin_q;
  logic             flag_q;
  logic             c0;
  logic             handshake;
  logic             last_beat;

  carry_init u_carry_init (
    .opsel      (opsel_e'(Opsel)),
    .mode       (mode_e'(Mode)),
    .carry_flag (flag_q),
    .c0         (c0)
  );

  assign handshake = (state == RUN) && SliceReady;
  assign last_beat = (idx_q == LAST_IDX);

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (handshake && last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The flag is written on the final handshake so it is already current while Done is high.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mode_q <= ARITH;
      idx_q  <= '0;
      cin_q  <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            mode_q <= mode_e'(Mode);
            idx_q  <= '0;
            cin_q  <= c0;
          end
        end
        RUN: begin
          if (handshake) begin
            if (!last_beat) begin
              idx_q <= idx_q + IDX_W'(1);
              cin_q <= (mode_q == ARITH) && SliceCarryOut;
            end else if (mode_q == ARITH) begin
              flag_q <= SliceCarryOut;
            end
          end
        end
        DONE: begin
          idx_q <= '0;
          cin_q <= 1'b0;
        end
        default: begin
          idx_q <= '0;
          cin_q <= 1'b0;
        end
      endcase
    end
  end

  assign SliceValid   = (state == RUN);
  assign Busy         = (state != IDLE);
  assign Done         = (state == DONE);
  assign SliceIdx     = idx_q;
  assign SliceCarryIn = cin_q;
  assign CarryFlag    = flag_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_carry_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_carry_seq : checks a 4-slice and a 1-slice sequencer against a
// transaction-level carry model
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_carry_seq;

  typedef struct {
    logic [2:0] op;
    logic       md;
    logic [3:0] couts;      // bit b = carry-out returned on beat b
    int         stall_beat;
    int         stall_len;
    bit         poke;       // pulse Start during RUN and during DONE
    logic       exp_flag;   // flag after the op, 4-slice instance
  } vec_t;

  logic Clk, Reset, Start, Mode, SliceReady, SliceCarryOut;
  logic [2:0] Opsel;
  bit sel;  // 0 = 4-slice instance, 1 = 1-slice instance

  logic sv0, busy0, done0, cin0, flag0, sv1, busy1, done1, cin1, flag1;
  logic [1:0] idx0;
  logic [0:0] idx1;
  logic start0, start1;

  assign start0 = Start & ~sel;
  assign start1 = Start & sel;

  alu_carry_seq #(.DATA_W(128), .SLICE_W(32)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .Start(start0), .Opsel(Opsel), .Mode(Mode),
    .SliceValid(sv0), .SliceReady(SliceReady), .SliceIdx(idx0),
    .SliceCarryIn(cin0), .SliceCarryOut(SliceCarryOut),
    .Busy(busy0), .Done(done0), .CarryFlag(flag0)
  );

  alu_carry_seq #(.DATA_W(64), .SLICE_W(64)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .Start(start1), .Opsel(Opsel), .Mode(Mode),
    .SliceValid(sv1), .SliceReady(SliceReady), .SliceIdx(idx1),
    .SliceCarryIn(cin1), .SliceCarryOut(SliceCarryOut),
    .Busy(busy1), .Done(done1), .CarryFlag(flag1)
  );

  logic sv, busy, done, cin, flag;
  logic [1:0] idx;
  assign sv   = sel ? sv1   : sv0;
  assign busy = sel ? busy1 : busy0;
  assign done = sel ? done1 : done0;
  assign cin  = sel ? cin1  : cin0;
  assign flag = sel ? flag1 : flag0;
  assign idx  = sel ? {1'b0, idx1} : idx0;

  int total = 0;
  int bad   = 0;
  bit mflag [2];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (dut%0d): got %0h expected %0h", name, sel ? 1 : 4, act, exp);
    end
  endtask

  // Initial carry straight from the operation table.
  function automatic logic c0_ref(input logic [2:0] op, input logic md, input logic f);
    if (md) return 1'b0;
    case (op)
      3'd1, 3'd4, 3'd7: return 1'b1;
      3'd3, 3'd5:       return f;
      default:          return 1'b0;
    endcase
  endfunction

  task automatic check_idle(input string tag, input logic exp_flag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " valid"}, sv, 0);
    check({tag, " idx"}, idx, 0);
    check({tag, " cin"}, cin, 0);
    check({tag, " flag"}, flag, exp_flag);
  endtask

  task automatic run_op(input vec_t v, input bit use_tab);
    int   ns = sel ? 1 : 4;
    logic exp_cin [4];
    logic new_flag;
    exp_cin[0] = c0_ref(v.op, v.md, mflag[sel]);
    for (int b = 1; b < 4; b++) exp_cin[b] = v.md ? 1'b0 : v.couts[b-1];
    new_flag = v.md ? mflag[sel] : v.couts[ns-1];
    if (use_tab && !sel) new_flag = v.exp_flag;
    mflag[sel] = new_flag;

    @(negedge Clk);
    Start = 1'b1; Opsel = v.op; Mode = v.md; SliceReady = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    for (int b = 0; b < ns; b++) begin
      int st = (b == v.stall_beat) ? v.stall_len : 0;
      for (int s = 0; s <= st; s++) begin
        SliceReady    = (s == st);
        SliceCarryOut = v.couts[b];
        Start         = v.poke && (b == 0) && (s == 0);
        Opsel         = 3'($urandom);
        Mode          = 1'($urandom);
        check("beat valid", sv, 1);
        check("beat busy", busy, 1);
        check("beat done", done, 0);
        check("beat idx", idx, b);
        check("beat cin", cin, exp_cin[b]);
        @(negedge Clk);
      end
    end
    Start = v.poke; SliceReady = 1'b0;
    check("done pulse", done, 1);
    check("done busy", busy, 1);
    check("done valid", sv, 0);
    @(negedge Clk);
    Start = 1'b0;
    check_idle("after op", new_flag);
    if (v.poke) begin
      @(negedge Clk);
      check("poke ignored busy", busy, 0);
      check("poke ignored done", done, 0);
    end
  endtask

  task automatic reset_mid_op();
    int   ns = sel ? 1 : 4;
    int   rb = (ns > 1) ? 1 : 0;
    vec_t v;
    v = '{op: 3'd2, md: 1'b0, couts: 4'b1111, stall_beat: 0, stall_len: 0, poke: 0, exp_flag: 1'b1};
    run_op(v, 1'b0);
    @(negedge Clk);
    Start = 1'b1; Opsel = 3'd2; Mode = 1'b0; SliceReady = 1'b1; SliceCarryOut = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    for (int b = 0; b < rb; b++) @(negedge Clk);
    check("abort beat idx", idx, rb);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    mflag[0] = 1'b0; mflag[1] = 1'b0;
    check_idle("abort", 1'b0);
    @(negedge Clk);
    check("abort no done", done, 0);
    check("abort stays idle", busy, 0);
  endtask

  vec_t tab [9];

  initial begin
    tab[0] = '{3'd2, 1'b0, 4'b1101, 9, 0, 0, 1'b1};  // ADD, carries 1,0,1,1
    tab[1] = '{3'd3, 1'b0, 4'b0000, 9, 0, 0, 1'b0};  // ADC consumes flag=1
    tab[2] = '{3'd4, 1'b0, 4'b1111, 9, 0, 0, 1'b1};  // SUB
    tab[3] = '{3'd2, 1'b1, 4'b1111, 9, 0, 0, 1'b1};  // logic: flag held
    tab[4] = '{3'd2, 1'b0, 4'b0010, 2, 3, 0, 1'b0};  // backpressure on beat 2
    tab[5] = '{3'd5, 1'b0, 4'b1000, 9, 0, 1, 1'b1};  // SBB, Start pokes
    tab[6] = '{3'd7, 1'b0, 4'b0000, 9, 0, 0, 1'b0};  // NEG
    tab[7] = '{3'd6, 1'b0, 4'b1000, 0, 2, 0, 1'b1};  // DEC, stall beat 0
    tab[8] = '{3'd1, 1'b0, 4'b0000, 9, 0, 1, 1'b0};  // INC

    Reset = 1'b1; Start = 1'b0; Opsel = '0; Mode = 1'b0;
    SliceReady = 1'b0; SliceCarryOut = 1'b0; sel = 1'b0;
    mflag[0] = 1'b0; mflag[1] = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check_idle("reset", 1'b0);
    sel = 1'b1;
    check_idle("reset", 1'b0);

    for (int c = 0; c < 2; c++) begin
      sel = (c == 1);
      foreach (tab[i]) run_op(tab[i], 1'b1);
      for (int r = 0; r < 30; r++) begin
        vec_t v;
        v.op         = 3'($urandom);
        v.md         = ($urandom_range(0, 3) == 0);
        v.couts      = 4'($urandom);
        v.stall_beat = $urandom_range(0, 3);
        v.stall_len  = $urandom_range(0, 3);
        v.poke       = 1'($urandom);
        v.exp_flag   = 1'b0;
        run_op(v, 1'b0);
      end
      reset_mid_op();
      // Back to normal operation after an abort.
      run_op(tab[0], 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
